// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/FETCH_IMM/MEM/WB control that owns pc/ir/imm/mdr and the shared memory port.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after every write-back.
module cpu_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              dec_reg_write,
  input  logic              dec_mem_read,
  input  logic              dec_mem_write,
  input  logic              dec_two_byte,
  input  logic [ADDR_W-1:0] dmem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic [7:0]        imm,
  output logic [7:0]        mdr,
  output logic              rf_we,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_MEM,
    S_WB,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        imm_q, imm_d;
  logic [7:0]        mdr_q, mdr_d;

  // Async reset returns to IDLE, so mem_req drops immediately even mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      mdr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    mdr_d    = mdr_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    rf_we    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_INC;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[7:4] == 4'hF)  state_d = S_HALT;
        else if (dec_two_byte)  state_d = S_FETCH_IMM;
        else                    state_d = S_WB;
      end
      S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_d   = mem_rdata;
          pc_d    = pc_q + PC_INC;
          state_d = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = dec_mem_write;
        mem_addr = dmem_addr;
        if (mem_ack) begin
          if (dec_mem_read) mdr_d = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we  = dec_reg_write;
        retire = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
      S_HALT: halted = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign pc  = pc_q;
  assign ir  = ir_q;
  assign imm = imm_q;
  assign mdr = mdr_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory model with programmable wait states and a small opcode decoder.
// A second instance with RESET_PC=0xFF covers PC wrap inside a two-byte instruction.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic [7:0] mem [256];
  int         n_wait;
  int         wcnt;
  logic       stray_ack;
  int         cyc;

  int n_tests = 0;
  int n_fail  = 0;

  // {reg_write, mem_read, mem_write, two_byte}: 1x ALU, 9x LOAD, Dx STORE, rest NOP/HLT.
  function automatic logic [3:0] decode(input logic [7:0] op);
    case (op[7:4])
      4'h1:    decode = 4'b1000;
      4'h9:    decode = 4'b1101;
      4'hD:    decode = 4'b0011;
      default: decode = 4'b0000;
    endcase
  endfunction

  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_two_byte;
  logic [7:0] dmem_addr, mem_addr, mem_rdata, pc, ir, imm, mdr;
  logic       mem_req, mem_we, mem_ack, rf_we, retire, halted;
  logic       step;

  assign {dec_reg_write, dec_mem_read, dec_mem_write, dec_two_byte} = decode(ir);
  assign dmem_addr = imm;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_req && (wcnt >= n_wait)) || stray_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wcnt <= 0;
    else if (mem_req && mem_ack) wcnt <= 0;
    else if (mem_req)          wcnt <= wcnt + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int         n_retire, n_rfwe, n_req, n_wr;
  logic [7:0] last_wr_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      n_retire = 0; n_rfwe = 0; n_req = 0; n_wr = 0; last_wr_addr = 8'h00;
    end else begin
      if (retire)  n_retire++;
      if (rf_we)   n_rfwe++;
      if (mem_req) n_req++;
      if (mem_req && mem_ack && mem_we) begin
        n_wr++;
        last_wr_addr = mem_addr;
      end
    end
  end

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_two_byte(dec_two_byte),
    .dmem_addr(dmem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc), .ir(ir), .imm(imm), .mdr(mdr),
    .rf_we(rf_we), .retire(retire), .halted(halted)
  );

  // Wrap instance: zero-wait memory, read-only view of the same array.
  logic       w_reg_write, w_mem_read, w_mem_write, w_two_byte;
  logic [7:0] w_mem_addr, w_pc, w_ir, w_imm, w_mdr;
  logic       w_req, w_we, w_rf_we, w_retire, w_halted;
  logic       step2;
  assign {w_reg_write, w_mem_read, w_mem_write, w_two_byte} = decode(w_ir);

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'hFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step2),
`endif
    .dec_reg_write(w_reg_write), .dec_mem_read(w_mem_read),
    .dec_mem_write(w_mem_write), .dec_two_byte(w_two_byte),
    .dmem_addr(w_imm), .mem_req(w_req), .mem_we(w_we), .mem_addr(w_mem_addr),
    .mem_ack(w_req), .mem_rdata(mem[w_mem_addr]), .pc(w_pc), .ir(w_ir), .imm(w_imm), .mdr(w_mdr),
    .rf_we(w_rf_we), .retire(w_retire), .halted(w_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_prog(input int waits);
    rst_n     = 1'b0;
    n_wait    = waits;
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fetch_c, halt_c, req_snap;
    rst_n = 1'b0; rst2_n = 1'b0; stray_ack = 1'b0; n_wait = 0;
    step = 1'b1; step2 = 1'b1; cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // One-byte ALU op, reset values first.
    start_prog(0);
    mem[0] = 8'h16;
    check("rst_req", mem_req, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_flags", {mem_we, rf_we, retire, halted}, 4'b0000);
    check("rst_regs", {ir, imm, mdr}, 24'h0);
    rst_n = 1'b1;
    tick;
    check("alu_c1_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    tick;
    check("alu_c2_dec", {mem_req, retire, ir, pc}, {1'b0, 1'b0, 8'h16, 8'h01});
    tick;
    check("alu_c3_wb", {rf_we, retire, pc}, {1'b1, 1'b1, 8'h01});

    // LOAD with zero-wait memory.
    start_prog(0);
    mem[0] = 8'h94; mem[1] = 8'h20; mem[8'h20] = 8'h5A;
    rst_n = 1'b1;
    tick; check("ld_c1", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    tick; check("ld_c2", {mem_req, ir, pc}, {1'b0, 8'h94, 8'h01});
    tick; check("ld_c3", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h01});
    tick; check("ld_c4", {mem_req, mem_we, mem_addr, imm}, {1'b1, 1'b0, 8'h20, 8'h20});
    tick; check("ld_c5", {rf_we, retire, mdr, pc}, {1'b1, 1'b1, 8'h5A, 8'h02});

    // STORE with two wait states per access.
    start_prog(2);
    check("rst_mdr_clr", mdr, 8'h00);
    mem[0] = 8'hD4; mem[1] = 8'h30;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick; check($sformatf("st_fetch_c%0d", c), {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    end
    tick; check("st_dec", mem_req, 0);
    for (int c = 5; c <= 7; c++) begin
      tick; check($sformatf("st_imm_c%0d", c), {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h01});
    end
    for (int c = 8; c <= 10; c++) begin
      tick; check($sformatf("st_mem_c%0d", c), {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 8'h30});
    end
    tick; check("st_wb", {rf_we, retire, pc}, {1'b0, 1'b1, 8'h02});
    tick;
    check("st_counts", {n_retire[7:0], n_rfwe[7:0], n_wr[7:0], last_wr_addr}, {8'd1, 8'd0, 8'd1, 8'h30});

    // Five undefined-opcode NOPs then HLT at 0x05.
    start_prog(0);
    for (int i = 0; i < 5; i++) mem[i] = 8'h00;
    mem[5] = 8'hF0;
    rst_n = 1'b1;
    fetch_c = -1; halt_c = -1;
    for (int i = 0; i < 100 && halt_c < 0; i++) begin
      tick;
      if (fetch_c < 0 && mem_req && mem_addr == 8'h05) fetch_c = cyc;
      if (halted) halt_c = cyc;
    end
    check("hlt_seen", (halt_c >= 0), 1);
    check("hlt_latency", halt_c - fetch_c, 2);
    check("hlt_pc", pc, 8'h06);
    req_snap = n_req;
    for (int i = 0; i < 50; i++) begin
      stray_ack = (i % 3 == 0);
      tick;
    end
    stray_ack = 1'b0;
    check("hlt_no_req", n_req - req_snap, 0);
    check("hlt_sticky", {halted, ir, pc}, {1'b1, 8'hF0, 8'h06});
    check("hlt_nop_retire", {n_retire[7:0], n_rfwe[7:0]}, {8'd5, 8'd0});

    // PC wrap: LOAD at 0xFF, immediate from 0x00.
    mem[8'hFF] = 8'h94; mem[0] = 8'h10; mem[8'h10] = 8'h77;
    rst2_n = 1'b1;
    tick; check("wrap_fetch", {w_req, w_mem_addr}, {1'b1, 8'hFF});
    tick; check("wrap_pc_dec", w_pc, 8'h00);
    tick; check("wrap_imm_addr", {w_req, w_we, w_mem_addr}, {1'b1, 1'b0, 8'h00});
    tick; check("wrap_mem_addr", {w_req, w_mem_addr}, {1'b1, 8'h10});
    tick; check("wrap_wb", {w_retire, w_rf_we, w_imm, w_mdr, w_pc}, {1'b1, 1'b1, 8'h10, 8'h77, 8'h01});
    rst2_n = 1'b0;

    // Async reset during a MEM wait state.
    start_prog(5);
    mem[0] = 8'h94; mem[1] = 8'h20; mem[8'h20] = 8'h5A;
    rst_n = 1'b1;
    fetch_c = -1;
    for (int i = 0; i < 60 && fetch_c < 0; i++) begin
      tick;
      if (mem_req && mem_addr == 8'h20) fetch_c = i;
    end
    check("rstmem_reached", (fetch_c >= 0), 1);
    tick;
    check("rstmem_pending", {mem_req, mem_addr}, {1'b1, 8'h20});
    rst_n = 1'b0;
    #1;
    check("rstmem_req_drop", mem_req, 0);
    check("rstmem_regs", {pc, ir, imm}, {8'h00, 8'h00, 8'h00});
    @(negedge clk);
    n_wait = 0;
    rst_n = 1'b1;
    tick; check("rstmem_refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: no FETCH after WB until step rises.
    start_prog(0);
    mem[0] = 8'h16; mem[1] = 8'h16;
    step = 1'b0;
    rst_n = 1'b1;
    tick; tick; tick;
    check("ss_wb", retire, 1);
    req_snap = n_req;
    for (int i = 0; i < 10; i++) tick;
    check("ss_paused", n_req - req_snap, 0);
    step = 1'b1;
    tick;
    check("ss_resume", {mem_req, mem_addr}, {1'b1, 8'h01});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
